// File: rtl/sprite_layer.sv
// Animated, scalable sprite overlay with a 3-stage pixel pipeline.
// Optional horizontal mirroring is built in when SPRITE_MIRROR_EN is defined.
module sprite_layer #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int FRAMES     = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int ANIM_DIV   = 8,
  parameter int TRANSP_IDX = 0,
  localparam int AW = $clog2(FRAMES*SPR_W*SPR_H)
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic [9:0]    sprite_x,
  input  logic [9:0]    sprite_y,
  input  logic          anim_en,
  input  logic [3:0]    bg_red,
  input  logic [3:0]    bg_green,
  input  logic [3:0]    bg_blue,
`ifdef SPRITE_MIRROR_EN
  input  logic          mirror,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [3:0]    rom_q,
  output logic [3:0]    pal_index,
  input  logic [3:0]    pal_red,
  input  logic [3:0]    pal_green,
  input  logic [3:0]    pal_blue,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          hit
);

  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [11:0] BOX_W = 12'(SPR_W << SCALE_LOG2);
  localparam logic [11:0] BOX_H = 12'(SPR_H << SCALE_LOG2);

  logic [9:0]    pos_x, pos_y;
  logic [FW-1:0] frame_idx;
  logic [CW-1:0] anim_cnt;
  logic          mirror_q;
  logic          frame_start;

  logic [10:0]   dx, dy, tx, ty, tx_eff;
  logic          in_box;
  logic [AW-1:0] addr_next;

  logic          s1_in, s1_blank, s2_in, s2_blank;
  logic [11:0]   s1_bg, s2_bg;

  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign pal_index   = rom_q;

  // Frame-level state only moves on the first pixel of a frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x     <= '0;
      pos_y     <= '0;
      mirror_q  <= 1'b0;
      anim_cnt  <= '0;
      frame_idx <= '0;
    end else if (frame_start) begin
      pos_x <= sprite_x;
      pos_y <= sprite_y;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= mirror;
`else
      mirror_q <= 1'b0;
`endif
      if (anim_en) begin
        if (anim_cnt == CW'(ANIM_DIV-1)) begin
          anim_cnt  <= '0;
          frame_idx <= (frame_idx == FW'(FRAMES-1)) ?
                       '0 : frame_idx + FW'(1);
        end else begin
          anim_cnt <= anim_cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, pos_x};
    dy     = {1'b0, DrawY} - {1'b0, pos_y};
    in_box = !dx[10] && ({1'b0, dx} < BOX_W) &&
             !dy[10] && ({1'b0, dy} < BOX_H);
    tx     = dx >> SCALE_LOG2;
    ty     = dy >> SCALE_LOG2;
    tx_eff = mirror_q ? (11'(SPR_W-1) - tx) : tx;
    addr_next = '0;
    if (in_box)
      addr_next = AW'(32'(frame_idx) * 32'(SPR_W*SPR_H) +
                      32'(ty) * 32'(SPR_W) + 32'(tx_eff));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      s1_in    <= 1'b0;
      s1_blank <= 1'b0;
      s1_bg    <= '0;
      s2_in    <= 1'b0;
      s2_blank <= 1'b0;
      s2_bg    <= '0;
    end else begin
      rom_addr <= addr_next;
      s1_in    <= in_box;
      s1_blank <= blank;
      s1_bg    <= {bg_red, bg_green, bg_blue};
      s2_in    <= s1_in;
      s2_blank <= s1_blank;
      s2_bg    <= s1_bg;
    end
  end

  // rom_q lines up with stage 2 because the ROM adds one cycle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      {red, green, blue} <= '0;
      hit                <= 1'b0;
    end else if (!s2_blank) begin
      {red, green, blue} <= '0;
      hit                <= 1'b0;
    end else if (s2_in && (rom_q != 4'(TRANSP_IDX))) begin
      {red, green, blue} <= {pal_red, pal_green, pal_blue};
      hit                <= 1'b1;
    end else begin
      {red, green, blue} <= s2_bg;
      hit                <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer: default instance plus a 2x-scaled one.
// ROM index = addr[3:0]; palette r=idx, g=~idx, b=idx^4'hA.
module tb_sprite_layer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        blank, anim_en, mirror;
  logic [3:0]  bg_red, bg_green, bg_blue;

  logic [11:0] rom_addr, rom2_addr;
  logic [3:0]  rom_q, rom2_q, pal_index, pal2_index;
  logic [3:0]  red, green, blue, red2, green2, blue2;
  logic        hit, hit2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_q  <= rom_addr[3:0];
  always_ff @(posedge clk) rom2_q <= rom2_addr[3:0];

  sprite_layer u_dut (
    .vga_clk(clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .anim_en(anim_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
`ifdef SPRITE_MIRROR_EN
    .mirror(mirror),
`endif
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_index), .pal_green(~pal_index),
    .pal_blue(pal_index ^ 4'hA),
    .red(red), .green(green), .blue(blue), .hit(hit)
  );

  sprite_layer #(.SCALE_LOG2(1)) u_dut2 (
    .vga_clk(clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .anim_en(anim_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
`ifdef SPRITE_MIRROR_EN
    .mirror(1'b0),
`endif
    .rom_addr(rom2_addr), .rom_q(rom2_q), .pal_index(pal2_index),
    .pal_red(pal2_index), .pal_green(~pal2_index),
    .pal_blue(pal2_index ^ 4'hA),
    .red(red2), .green(green2), .blue(blue2), .hit(hit2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int rgbh(input int r, input int g,
                              input int b, input int h);
    return (r << 9) | (g << 5) | (b << 1) | h;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  initial begin
    reset_n  = 1'b0;
    blank    = 1'b1;
    anim_en  = 1'b0;
    mirror   = 1'b0;
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    {bg_red, bg_green, bg_blue} = {4'd3, 4'd4, 4'd5};
    pix(0, 0);

    #3;
    check("reset_rgbh", int'({red, green, blue, hit}), 0);
    check("reset_addr", int'(rom_addr), 0);
    #9 reset_n = 1'b1;

    // latency and address at (105,52)
    step(1);
    pix(105, 52);
    step(1);
    check("addr_69", int'(rom_addr), 69);
    step(1);
    check("lat_not_yet", int'({red, green, blue, hit}), rgbh(3, 4, 5, 0));
    step(1);
    check("lat_3cyc", int'({red, green, blue, hit}), rgbh(5, 10, 15, 1));

    // transparency, blanking, outside box
    pix(100, 50);
    step(3);
    check("transp_bg", int'({red, green, blue, hit}), rgbh(3, 4, 5, 0));
    blank = 1'b0;
    step(3);
    check("blanked", int'({red, green, blue, hit}), 0);
    blank = 1'b1;
    pix(99, 50);
    step(3);
    check("outside", int'({red, green, blue, hit}), rgbh(3, 4, 5, 0));

    // right-edge clipping, no wrap to column 0
    sprite_x = 10'd620;
    pix(0, 0);
    step(1);
    pix(5, 52);
    step(3);
    check("clip_nowrap", int'({red, green, blue, hit}), rgbh(3, 4, 5, 0));
    pix(639, 52);
    step(1);
    check("clip_addr", int'(rom_addr), 83);
    step(2);
    check("clip_rgbh", int'({red, green, blue, hit}), rgbh(3, 12, 9, 1));

    // 2x scale instance
    sprite_x = 10'd0;
    sprite_y = 10'd0;
    pix(0, 0);
    step(1);
    pix(63, 63);
    step(1);
    check("scale_addr", int'(rom2_addr), 1023);
    check("unscaled_out", int'(rom_addr), 0);
    step(2);
    check("scale_rgbh", int'({red2, green2, blue2, hit2}),
          rgbh(15, 0, 5, 1));
    pix(64, 0);
    step(1);
    check("scale_edge_addr", int'(rom2_addr), 0);
    step(2);
    check("scale_edge_rgbh", int'({red2, green2, blue2, hit2}),
          rgbh(3, 4, 5, 0));

    // animation: frame index steps every 8 frame starts
    anim_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      pix(0, 0);
      step(1);
      pix(1, 0);
      step(1);
      check($sformatf("anim_k%0d", k), int'(rom_addr),
            ((k / 8) % 4) * 1024 + 1);
    end
    anim_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pix(0, 0);
      step(1);
      pix(1, 0);
      step(1);
    end
    check("anim_hold", int'(rom_addr), 1);

    // position change mid-frame waits for the next frame start
    sprite_x = 10'd200;
    pix(1, 0);
    step(1);
    check("mid_frame_old", int'(rom_addr), 1);
    pix(0, 0);
    step(1);
    pix(1, 0);
    step(1);
    check("new_frame_out", int'(rom_addr), 0);
    pix(201, 0);
    step(1);
    check("new_frame_in", int'(rom_addr), 1);

    // asynchronous reset mid-line
    pix(205, 0);
    step(3);
    check("pre_reset_hit", int'({red, green, blue, hit}),
          rgbh(5, 10, 15, 1));
    #3 reset_n = 1'b0;
    #1;
    check("async_rgbh", int'({red, green, blue, hit}), 0);
    check("async_addr", int'(rom_addr), 0);
    #2 reset_n = 1'b1;
    pix(5, 0);
    step(1);
    check("post_reset_pos0", int'(rom_addr), 5);
    step(2);
    check("post_reset_rgbh", int'({red, green, blue, hit}),
          rgbh(5, 10, 15, 1));

`ifdef SPRITE_MIRROR_EN
    sprite_x = 10'd0;
    mirror   = 1'b1;
    pix(0, 0);
    step(2);
    check("mirror_addr", int'(rom_addr), 31);
    mirror = 1'b0;
    pix(1, 0);
    step(1);
    check("mirror_mid", int'(rom_addr), 30);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_layer.md
SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 SHALL have parameters: SPR_W default 32 (texels per row); SPR_H default 32 (rows); FRAMES default 4 (animation frames in ROM); SCALE_LOG2 default 0 (on-screen magnification 2^SCALE_LOG2); ANIM_DIV default 8 (video frames per animation step); TRANSP_IDX default 0 (palette index treated as transparent).
REQ-002 SHALL derive AW = clog2(FRAMES*SPR_W*SPR_H), the ROM address width.
REQ-003 SHALL have ports: vga_clk in 1, the pixel clock and only clock; reset_n in 1, asynchronous active-low reset.
REQ-004 SHALL have ports: DrawX in 10, current pixel column; DrawY in 10, current pixel row; blank in 1, high = active video.
REQ-005 SHALL have ports: sprite_x in 10, sprite_y in 10, top-left screen position; anim_en in 1, enables frame advance; bg_red, bg_green, bg_blue in 4 each, underlying layer colour.
REQ-006 SHALL have ports: rom_addr out AW, to external synchronous ROM (1-cycle read latency); rom_q in 4, palette index from ROM; pal_index out 4; pal_red, pal_green, pal_blue in 4 each, combinational palette lookup.
REQ-007 SHALL have ports: red, green, blue out 4 each, registered pixel colour; hit out 1, registered, high when an opaque sprite texel is output.

Function
REQ-008 SHALL define frame start as DrawX==0 and DrawY==0 sampled on a vga_clk edge.
REQ-009 SHALL latch sprite_x/sprite_y into internal position registers only at frame start; mid-frame changes take effect next frame.
REQ-010 SHALL hold an animation counter (0..ANIM_DIV-1) and a frame index (0..FRAMES-1), both advanced only at frame start with anim_en high.
REQ-011 SHALL, at frame start with anim_en high, increment the animation counter; on wrap from ANIM_DIV-1 to 0 it SHALL advance the frame index, wrapping FRAMES-1 to 0.
REQ-012 SHALL, with anim_en low, hold counter and frame index unchanged.
REQ-013 SHALL compute dx = DrawX - pos_x and dy = DrawY - pos_y in 11-bit two's complement; in-box when 0 <= dx < SPR_W<<SCALE_LOG2 and 0 <= dy < SPR_H<<SCALE_LOG2.
REQ-014 SHALL form tx = dx>>SCALE_LOG2, ty = dy>>SCALE_LOG2, rom_addr = frame*SPR_W*SPR_H + ty*SPR_W + tx; rom_addr SHALL be 0 when not in-box.
REQ-015 SHALL register rom_addr, in-box, blank and bg colour (stage 1), delay in-box/blank/bg one further cycle alongside the ROM read (stage 2), and register outputs (stage 3); total latency DrawX/DrawY to red/green/blue/hit is exactly 3 vga_clk cycles.
REQ-016 SHALL drive pal_index = rom_q combinationally.
REQ-017 SHALL, at stage 3: delayed blank low -> RGB 0, hit 0; else in-box and rom_q != TRANSP_IDX -> pal colour, hit 1; else bg colour, hit 0.
REQ-018 SHALL treat sprites partly off-screen (pos_x+width > 639) by clipping naturally; no wrap to column 0.

Reset
REQ-019 SHALL, on reset_n low, asynchronously clear all pipeline registers, rom_addr, red/green/blue, hit, position registers, animation counter and frame index to 0.
REQ-020 SHALL, after reset_n deasserts mid-frame, output bg colour (or 0 when blanked) with hit 0 until in-box pixels reach stage 3, position regs remaining 0 until next frame start.

Configuration
REQ-021 SHALL, when SPRITE_MIRROR_EN is defined, add input mirror (1 bit, latched at frame start like position); mirror high uses tx' = SPR_W-1-tx in REQ-014.
REQ-022 SHALL, when SPRITE_MIRROR_EN is undefined, have no mirror port and use tx unmodified.

Verification
REQ-023 Reset: reset_n low mid-line -> red/green/blue = 0, hit = 0, rom_addr = 0 immediately, before any clock edge.
REQ-024 Latency/addr: defaults, sprite at (100,50), frame 0, DrawX=105, DrawY=52, blank=1 -> rom_addr = 69 one cycle later; palette colour on outputs 3 cycles after input.
REQ-025 Transparency: ROM returns 0 at in-box pixel with bg=(3,4,5) -> outputs (3,4,5), hit 0; with blank=0 -> (0,0,0).
REQ-026 Scale: SCALE_LOG2=1, sprite at (0,0), pixel (63,63) -> rom_addr 1023 in-box; pixel (64,0) -> not in-box, bg output.
REQ-027 Animation: anim_en=1, ANIM_DIV=8, FRAMES=4 -> frame index steps every 8 frame starts, 0->1->2->3->0 after 32; anim_en=0 holds value.
REQ-028 Mirror (SPRITE_MIRROR_EN defined): mirror=1, sprite at (0,0), pixel (0,0) -> rom_addr = 31; position/mirror change mid-frame not applied until next frame start.
